// File: rtl/zueirai_int_pkg.sv
// Shared definitions for the interrupt arbiter slice.
//   NUM_CH      : number of interrupt channels
//   RISE / FALL : bit positions inside a channel's 2-bit edge-type field
//   state_t     : arbiter handshake states
//   pick_winner : arbitration helper (high class first, then lowest index)
package zueirai_int_pkg;

  localparam int NUM_CH = 8;
  localparam int RISE   = 0;
  localparam int FALL   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  function automatic logic [2:0] pick_winner(input logic [NUM_CH-1:0] cand,
                                             input logic [NUM_CH-1:0] prio_hi);
    logic [NUM_CH-1:0] pool;
    logic [2:0]        win;
    pool = ((cand & prio_hi) != '0) ? (cand & prio_hi) : cand;
    win  = 3'd0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pool[i]) win = 3'(i);
    end
    return win;
  endfunction

endpackage

// File: rtl/zueirai_int_edge.sv
// Per-channel input synchronizer and edge qualifier.
//   clk, rst  : clock, async active-high reset
//   din       : raw interrupt line (asynchronous to clk)
//   edge_type : [RISE] rising-edge sensitive, [FALL] falling-edge sensitive
//   en        : channel enable
//   evt       : one-cycle qualified edge event (combinational from flops)
module zueirai_int_edge
  import zueirai_int_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic [1:0] edge_type,
  input  logic       en,
  output logic       evt
);

  logic sync1, sync2, prev;

  // prev resets to 0 so a line held high through reset looks like a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  logic rise, fall;
  assign rise = sync2 & ~prev;
  assign fall = ~sync2 & prev;
  assign evt  = en & ((edge_type[RISE] & rise) | (edge_type[FALL] & fall));

endmodule

// File: rtl/zueirai_int_arbiter.sv
// Interrupt arbiter: records qualified edges into a pending register and
// runs a non-nesting request/acknowledge/end-of-interrupt handshake.
//   clk, rst   : clock, async active-high reset
//   int_io     : raw interrupt lines
//   int_en     : per-channel enable
//   int_type   : 2 bits per channel, [2i]=rising, [2i+1]=falling
//   prio_hi    : per-channel high-priority class
//   gie        : global interrupt enable
//   pend_clr   : write-one-to-clear strobe for pend
//   int_ack    : CPU accepts request
//   int_eoi    : CPU returns from ISR
//   int_req    : request to CPU
//   int_vec    : requesting / in-service channel index
//   int_active : ISR in service
//   pend       : pending register
//
// state | meaning
// IDLE  | no handshake; issue request when gie and a candidate exists
// REQ   | int_req and int_vec held until int_ack
// SERV  | ISR running, no nesting; int_eoi returns to IDLE
module zueirai_int_arbiter
  import zueirai_int_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     int_io,
  input  logic [NUM_CH-1:0]     int_en,
  input  logic [2*NUM_CH-1:0]   int_type,
  input  logic [NUM_CH-1:0]     prio_hi,
  input  logic                  gie,
  input  logic [NUM_CH-1:0]     pend_clr,
  input  logic                  int_ack,
  input  logic                  int_eoi,
  output logic                  int_req,
  output logic [2:0]            int_vec,
  output logic                  int_active,
  output logic [NUM_CH-1:0]     pend
);

  logic [NUM_CH-1:0] evt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    zueirai_int_edge u_edge (
      .clk       (clk),
      .rst       (rst),
      .din       (int_io[g]),
      .edge_type (int_type[2*g+1:2*g]),
      .en        (int_en[g]),
      .evt       (evt[g])
    );
  end

  state_t            state;
  logic [NUM_CH-1:0] cand;
  logic [NUM_CH-1:0] ack_clr;

  assign cand    = pend & int_en;
  assign ack_clr = (state == REQ && int_ack) ? (NUM_CH'(1) << int_vec) : '0;

  // Set is OR-ed in after the clear so a coincident edge keeps the bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~(pend_clr | ack_clr)) | evt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      int_vec    <= 3'd0;
      int_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gie && (cand != '0)) begin
            state   <= REQ;
            int_req <= 1'b1;
            int_vec <= pick_winner(cand, prio_hi);
          end
        end
        REQ: begin
          if (int_ack) begin
            state      <= SERV;
            int_req    <= 1'b0;
            int_active <= 1'b1;
          end
        end
        SERV: begin
          if (int_eoi) begin
            state      <= IDLE;
            int_active <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          int_req    <= 1'b0;
          int_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zueirai_int_arbiter.sv
module tb_zueirai_int_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  int_io = '0;
  logic [7:0]  int_en = '0;
  logic [15:0] int_type = '0;
  logic [7:0]  prio_hi = '0;
  logic        gie = 1'b0;
  logic [7:0]  pend_clr = '0;
  logic        int_ack = 1'b0;
  logic        int_eoi = 1'b0;
  logic        int_req;
  logic [2:0]  int_vec;
  logic        int_active;
  logic [7:0]  pend;

  int n_cmp = 0;
  int n_bad = 0;

  zueirai_int_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .int_io     (int_io),
    .int_en     (int_en),
    .int_type   (int_type),
    .prio_hi    (prio_hi),
    .gie        (gie),
    .pend_clr   (pend_clr),
    .int_ack    (int_ack),
    .int_eoi    (int_eoi),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_active (int_active),
    .pend       (pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // io_seen[k] = int_io value sampled k edges ago (0 = most recent).
  // An edge is recognised when the values seen 2 and 3 edges back differ.
  bit [7:0] io_seen [0:2];
  bit [7:0] m_pend = '0;
  int       m_mode = 0;   // 0 idle, 1 requesting, 2 in service
  int       m_vec  = 0;
  bit [7:0] m_set, m_cand, m_clr, m_pool;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      io_seen[0] = '0; io_seen[1] = '0; io_seen[2] = '0;
      m_pend = '0; m_mode = 0; m_vec = 0;
    end else begin
      m_set = '0;
      for (int i = 0; i < 8; i++) begin
        if (int_en[i]) begin
          if (int_type[2*i]   &&  io_seen[1][i] && !io_seen[2][i]) m_set[i] = 1'b1;
          if (int_type[2*i+1] && !io_seen[1][i] &&  io_seen[2][i]) m_set[i] = 1'b1;
        end
      end
      m_cand = m_pend & int_en;
      m_clr  = pend_clr;
      if (m_mode == 1 && int_ack) m_clr[m_vec] = 1'b1;
      if (m_mode == 0) begin
        if (gie && m_cand != 0) begin
          m_pool = ((m_cand & prio_hi) != 0) ? (m_cand & prio_hi) : m_cand;
          m_vec = 0;
          while (!m_pool[m_vec]) m_vec++;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (int_ack) m_mode = 2;
      end else begin
        if (int_eoi) m_mode = 0;
      end
      m_pend = (m_pend & ~m_clr) | m_set;
      io_seen[2] = io_seen[1];
      io_seen[1] = io_seen[0];
      io_seen[0] = int_io;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req", {15'd0, int_req}, 16'd0);
      chk("rst_active", {15'd0, int_active}, 16'd0);
      chk("rst_vec", {13'd0, int_vec}, 16'd0);
      chk("rst_pend", {8'd0, pend}, 16'd0);
    end else begin
      chk("mdl_pend", {8'd0, pend}, {8'd0, m_pend});
      chk("mdl_req", {15'd0, int_req}, {15'd0, (m_mode == 1)});
      chk("mdl_active", {15'd0, int_active}, {15'd0, (m_mode == 2)});
      if (m_mode != 0) chk("mdl_vec", {13'd0, int_vec}, 16'(m_vec));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_ack;
    int_ack = 1'b1; step(1); int_ack = 1'b0;
  endtask

  task automatic do_eoi;
    int_eoi = 1'b1; step(1); int_eoi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    step(2);
    chk("reset_pend", {8'd0, pend}, 16'h0000);
    chk("reset_req", {15'd0, int_req}, 16'h0000);
    rst = 1'b0;
    step(4);

    // single rising channel 2
    int_type = 16'h0010; int_en = 8'h04; gie = 1'b1; prio_hi = 8'h00;
    int_io = 8'h04;
    step(2);
    chk("c2_pend_early", {8'd0, pend}, 16'h0000);
    step(1);
    chk("c2_pend", {8'd0, pend}, 16'h0004);
    chk("c2_req_early", {15'd0, int_req}, 16'h0000);
    step(1);
    chk("c2_req", {15'd0, int_req}, 16'h0001);
    chk("c2_vec", {13'd0, int_vec}, 16'h0002);
    do_ack();
    chk("c2_pend_ack", {8'd0, pend}, 16'h0000);
    chk("c2_active", {15'd0, int_active}, 16'h0001);
    do_ack();
    chk("c2_ack_ignored", {15'd0, int_active}, 16'h0001);
    do_eoi();
    chk("c2_eoi", {15'd0, int_active}, 16'h0000);
    int_io = 8'h00;
    step(5);
    chk("c2_no_fall", {8'd0, pend}, 16'h0000);

    // priority: channels 1 and 6, 6 is high class
    int_type = 16'h1004; int_en = 8'h42; prio_hi = 8'h40;
    int_io = 8'h42;
    step(3);
    chk("pr_pend", {8'd0, pend}, 16'h0042);
    step(1);
    chk("pr_vec6", {13'd0, int_vec}, 16'h0006);
    do_ack(); do_eoi();
    step(1);
    chk("pr_vec1", {13'd0, int_vec}, 16'h0001);
    chk("pr_req1", {15'd0, int_req}, 16'h0001);
    do_ack(); do_eoi();
    int_io = 8'h00;
    step(5);

    // both edges on channel 0
    int_type = 16'h0003; int_en = 8'h01; prio_hi = 8'h00;
    int_io = 8'h01;
    step(4);
    chk("both_req1", {15'd0, int_req}, 16'h0001);
    do_ack();
    int_io = 8'h00;
    step(3);
    chk("both_pend_serv", {8'd0, pend}, 16'h0001);
    chk("both_active", {15'd0, int_active}, 16'h0001);
    do_eoi();
    step(1);
    chk("both_req2", {15'd0, int_req}, 16'h0001);
    do_ack(); do_eoi();
    step(2);

    // falling only on channel 0
    int_type = 16'h0002;
    int_io = 8'h01;
    step(5);
    chk("fall_no_rise", {8'd0, pend}, 16'h0000);
    int_io = 8'h00;
    step(3);
    chk("fall_pend", {8'd0, pend}, 16'h0001);
    step(1);
    chk("fall_req", {15'd0, int_req}, 16'h0001);
    do_ack(); do_eoi();
    step(5);
    chk("fall_once", {8'd0, pend}, 16'h0000);

    // set/ack collision on channel 3
    int_type = 16'h0040; int_en = 8'h08;
    int_io = 8'h08;
    step(4);
    chk("col_vec", {13'd0, int_vec}, 16'h0003);
    int_io = 8'h00;
    step(3);
    int_io = 8'h08;
    step(2);
    do_ack();
    chk("col_pend", {8'd0, pend}, 16'h0008);
    chk("col_active", {15'd0, int_active}, 16'h0001);
    do_eoi();
    step(1);
    chk("col_req2", {15'd0, int_req}, 16'h0001);
    do_ack(); do_eoi();
    int_io = 8'h00;
    step(5);

    // gie masking and pend_clr during request
    int_type = 16'h0100; int_en = 8'h10; gie = 1'b0;
    int_io = 8'h10;
    step(6);
    chk("gie_pend", {8'd0, pend}, 16'h0010);
    chk("gie_masked", {15'd0, int_req}, 16'h0000);
    gie = 1'b1;
    step(1);
    chk("gie_req", {15'd0, int_req}, 16'h0001);
    pend_clr = 8'h10;
    step(1);
    pend_clr = 8'h00;
    chk("clr_pend", {8'd0, pend}, 16'h0000);
    chk("clr_req_held", {15'd0, int_req}, 16'h0001);
    chk("clr_vec_held", {13'd0, int_vec}, 16'h0004);
    gie = 1'b0;
    step(2);
    chk("clr_req_gie0", {15'd0, int_req}, 16'h0001);
    do_ack(); do_eoi();
    gie = 1'b1;
    int_io = 8'h00;
    step(5);

    // reset during service
    int_type = 16'h4001; int_en = 8'h81;
    int_io = 8'h80;
    step(4);
    do_ack();
    chk("rs_active", {15'd0, int_active}, 16'h0001);
    int_io = 8'h81;
    step(3);
    chk("rs_pend_pre", {8'd0, pend}, 16'h0001);
    rst = 1'b1;
    int_io = 8'h80;
    #1;
    chk("rs_imm_req", {15'd0, int_req}, 16'h0000);
    chk("rs_imm_active", {15'd0, int_active}, 16'h0000);
    chk("rs_imm_vec", {13'd0, int_vec}, 16'h0000);
    chk("rs_imm_pend", {8'd0, pend}, 16'h0000);
    step(2);
    rst = 1'b0;
    step(2);
    chk("rs_pend_early", {8'd0, pend}, 16'h0000);
    step(1);
    chk("rs_pend", {8'd0, pend}, 16'h0080);
    step(1);
    chk("rs_vec", {13'd0, int_vec}, 16'h0007);
    do_ack(); do_eoi();
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/zueirai_int_arbiter.md
ZUEIRAI_INT_ARBITER -- requirements
Module: zueirai_int_arbiter

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 int_io  in  8  raw external interrupt lines, asynchronous to clk.
REQ-004 int_en  in  8  per-channel enable; 1 = channel may record and request.
REQ-005 int_type  in  16  2 bits per channel at [2i+1:2i].
- bit 2i: rising-edge sensitive.
- bit 2i+1: falling-edge sensitive.
- 11 = both edges; 00 = channel off.
REQ-006 prio_hi  in  8  1 = channel belongs to the high-priority class.
REQ-007 gie  in  1  global interrupt enable from the CPU status register.
REQ-008 pend_clr  in  8  software write-one-to-clear strobe for pending bits, one cycle wide.
REQ-009 int_ack  in  1  CPU accepts the request and enters the ISR, one cycle wide.
REQ-010 int_eoi  in  1  CPU end-of-interrupt (return from ISR), one cycle wide.
REQ-011 int_req  out  1  interrupt request to the CPU.
REQ-012 int_vec  out  3  index of the requesting or in-service channel.
REQ-013 int_active  out  1  an ISR is in service.
REQ-014 pend  out  8  pending register, readable by software.

Function
REQ-015 Each int_io bit SHALL pass through a 2-flop synchronizer followed by a previous-value register; edge detection compares the synchronizer output against the previous-value register.
REQ-016 A qualified edge on channel i SHALL set pend[i] on the third rising clk edge after int_io[i] is first captured.
- Qualified = the edge matches int_type and int_en[i]=1.
REQ-017 pend bits of channels later disabled SHALL be retained, but excluded from arbitration while int_en[i]=0.
REQ-018 Arbitration candidates SHALL be pend & int_en.
- High-priority class beats low-priority class.
- Within a class, the lowest index wins.
REQ-019 The state machine SHALL have three states: IDLE, REQ, SERV.
REQ-020 IDLE: if gie=1 and any candidate exists, go to REQ on the next edge, latch int_vec to the winner, and assert int_req.
REQ-021 REQ: int_req and int_vec SHALL be held stable until int_ack, regardless of gie, pend_clr or new arrivals.
REQ-022 REQ + int_ack: go to SERV, drop int_req, set int_active, and clear pend[int_vec].
REQ-023 SERV: no new request is issued (no nesting); on int_eoi, go to IDLE and drop int_active.
- A new request may assert on the cycle after the return to IDLE.
REQ-024 int_ack outside REQ and int_eoi outside SERV SHALL be ignored.
REQ-025 When set and clear of the same pend bit coincide in one cycle (edge vs. pend_clr or ack), set SHALL win and the bit remains 1.
REQ-026 pend_clr SHALL clear any bit except as given in REQ-025; clearing pend[int_vec] during REQ does not withdraw the request.
REQ-027 Request latency SHALL be 1 cycle: the pend bit is set at edge k, and int_req is high after edge k+1 when in IDLE with gie=1.

Reset
REQ-028 While rst=1:
- All outputs SHALL be 0.
- The state SHALL be IDLE.
- The synchronizer, previous-value register and pend SHALL be 0.
REQ-029 A line held high through reset release SHALL be treated as a rising edge after release.
REQ-030 Asserting rst mid-handshake (REQ or SERV) SHALL abandon the handshake with no residual pending bit.

Structure
REQ-031 Package zueirai_int_pkg SHALL hold:
- the state enum (IDLE, REQ, SERV);
- NUM_CH=8;
- edge-type constants: RISE=bit0, FALL=bit1.
REQ-032 Per-channel synchronizer and edge detector SHALL be sub-module zueirai_int_edge, instantiated 8 times.
- Ports: clk, rst, din, type[1:0], en, evt.

Verification
REQ-033 Single channel: int_type[5:4]=01, int_en=0x04, gie=1, rising edge on int_io[2] -> pend=0x04 after 3 edges, then int_req=1 with int_vec=2; ack -> pend=0x00, int_active=1; eoi -> IDLE.
REQ-034 Priority: edges on channels 1 and 6 in the same cycle, prio_hi=0x40 -> int_vec=6; after eoi -> int_vec=1.
REQ-035 Falling and both-edge types: type=11 on channel 0 with int_io[0] pulsed high then low -> two events recorded (second while in SERV), giving two service rounds; type=10 -> exactly one event on the falling edge only.
REQ-036 Collision: a new edge on channel 3 lands in the same cycle as int_ack for channel 3 -> pend[3] stays 1 and a second request follows the eoi.
REQ-037 Masking and clearing:
- gie=0 with pend=0x10 -> int_req stays 0; raising gie -> int_req on the next edge.
- pend_clr=0x10 in REQ -> int_req and int_vec stay held until ack.
REQ-038 Reset: assert rst during SERV -> all outputs 0 immediately; int_io[7]=1 at release with type rising -> pend=0x80 after 3 edges.
